pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 clk  input  1  pipeline clock; all state updates on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 stallreq_if  input  1  icache miss / fetch in flight.
REQ-004 stallreq_id  input  1  load-use hazard in decode.
REQ-005 stallreq_ex  input  1  multi-cycle ex op (mul/div) busy.
REQ-006 stallreq_mem  input  1  dcache access in flight.
REQ-007 excepttype  input  32  mem-stage exception code, 0 = none.
REQ-008 cp0_epc  input  32  EPC value for eret return.
REQ-009 stall  output  6  per-stage freeze: [0] pc, [1] if, [2] if/id, [3] id/ex, [4] ex/mem, [5] mem/wb; 1 = stop.
REQ-010 flush  output  1  one-cycle pipeline flush pulse.
REQ-011 new_pc  output  32  redirect target, valid only while flush=1.
REQ-012 stall_cnt  output  32  count of cycles with any stall bit set.

Function
REQ-013 State machine SHALL have states RUN, PEND, GUARD.
REQ-014 In RUN with excepttype=0, stall SHALL be combinational, highest stage wins: mem -> 6'b011111, ex -> 6'b001111, id -> 6'b000111, if -> 6'b000011, none -> 6'b000000.
REQ-015 A non-zero excepttype SHALL mask stallreq_mem, stallreq_ex and stallreq_id (faulting instruction performs no access).
REQ-016 In RUN, excepttype!=0 and stallreq_if=0: flush=1 and new_pc valid in the same cycle, stall=6'b000000, next state GUARD.
REQ-017 In RUN, excepttype!=0 and stallreq_if=1: flush=0, stall=6'b111111, target latched into pend_pc, next state PEND.
REQ-018 In PEND: stall=6'b111111 while stallreq_if=1; first cycle stallreq_if=0: flush=1, new_pc=pend_pc, stall=0, next state GUARD.
REQ-019 In GUARD (exactly one cycle): excepttype ignored, stall per REQ-014, flush=0, next state RUN.
REQ-020 Target: excepttype=32'h0000000e (eret) -> cp0_epc; any other non-zero code -> 32'hBFC00380.
REQ-021 PEND target SHALL be the value at entry; cp0_epc changes during PEND ignored.
REQ-022 new_pc SHALL be 32'h0 whenever flush=0.
REQ-023 flush SHALL never be high two consecutive cycles.
REQ-024 stall_cnt SHALL increment by 1 each cycle stall!=0, wrap 32'hFFFFFFFF -> 0, no saturation.
REQ-025 Requests arriving together with flush SHALL not raise stall that cycle; flushed stages drop them.

Reset
REQ-026 During rst: state=RUN, pend_pc=0, stall_cnt=0; outputs stall=0, flush=0, new_pc=0 irrespective of inputs.
REQ-027 rst asserted in PEND SHALL abandon the pending redirect; no flush after release.
REQ-028 First cycle after release SHALL behave as RUN.

Structure
REQ-029 Stall bus width, Stop/NoStop, exception codes, exception vector 32'hBFC00380 SHALL live in the shared defines file.
REQ-030 Single module; stall-priority encoder as combinational block, no sub-module.

Verification
REQ-031 stallreq_id=1, stallreq_ex=1 same cycle -> stall=6'b001111, stall_cnt +1.
REQ-032 excepttype=32'h8, stallreq_if=0 -> flush=1, new_pc=32'hBFC00380 same cycle; next cycle flush=0, state GUARD.
REQ-033 excepttype=32'he, cp0_epc=32'h80001000, stallreq_if=1 for 3 cycles -> stall=6'b111111 for 3 cycles, then flush=1, new_pc=32'h80001000.
REQ-034 excepttype=32'hc and stallreq_mem=1 -> stall=0, flush=1 (mem request masked).
REQ-035 rst pulsed during PEND -> no flush afterwards, stall=0, stall_cnt=0.
REQ-036 stall_cnt preset to 32'hFFFFFFFF via 2^32-1 stalled cycles (or force) + one stalled cycle -> stall_cnt=0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline controller: stall bus encoding,
// exception codes, the exception vector and the controller state type.
package pipe_ctrl_pkg;

  localparam int STALL_W = 6;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam logic [STALL_W-1:0] STALL_NONE = {STALL_W{NO_STOP}};
  localparam logic [STALL_W-1:0] STALL_ALL  = {STALL_W{STOP}};
  localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
  localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
  localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
  localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

  localparam logic [31:0] EXC_NONE   = 32'h0000_0000;
  localparam logic [31:0] EXC_ERET   = 32'h0000_000e;
  localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    PEND  = 2'd1,
    GUARD = 2'd2
  } ctrl_state_e;

  // The deepest requesting stage freezes itself and everything upstream.
  function automatic logic [STALL_W-1:0] stallPriority(input logic reqMem,
                                                       input logic reqEx,
                                                       input logic reqId,
                                                       input logic reqIf);
    if (reqMem)     return STALL_MEM;
    else if (reqEx) return STALL_EX;
    else if (reqId) return STALL_ID;
    else if (reqIf) return STALL_IF;
    else            return STALL_NONE;
  endfunction

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stage freeze encoding, exception redirect with a
// pending state for in-flight fetches, and a stalled-cycle counter.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               stallreq_if,
  input  logic               stallreq_id,
  input  logic               stallreq_ex,
  input  logic               stallreq_mem,
  input  logic [31:0]        excepttype,
  input  logic [31:0]        cp0_epc,
  output logic [STALL_W-1:0] stall,
  output logic               flush,
  output logic [31:0]        new_pc,
  output logic [31:0]        stall_cnt
);

  ctrl_state_e        state_q, state_d;
  logic [31:0]        pendPc_q, pendPc_d;
  logic [31:0]        stallCnt_q;

  logic               excActive;
  logic [31:0]        excTarget;
  logic [STALL_W-1:0] reqStall;
  logic [STALL_W-1:0] stallNow;
  logic               flushNow;
  logic [31:0]        newPcNow;

  assign excActive = (excepttype != EXC_NONE);
  assign excTarget = (excepttype == EXC_ERET) ? cp0_epc : EXC_VECTOR;
  assign reqStall  = stallPriority(stallreq_mem, stallreq_ex, stallreq_id, stallreq_if);

  // A faulting instruction's own mem/ex/id requests never reach the stall
  // bus: the exception branch either flushes or freezes everything for fetch.
  always_comb begin
    state_d  = state_q;
    pendPc_d = pendPc_q;
    stallNow = STALL_NONE;
    flushNow = 1'b0;
    newPcNow = 32'h0;
    unique case (state_q)
      RUN: begin
        if (excActive) begin
          if (stallreq_if) begin
            stallNow = STALL_ALL;
            pendPc_d = excTarget;
            state_d  = PEND;
          end else begin
            flushNow = 1'b1;
            newPcNow = excTarget;
            state_d  = GUARD;
          end
        end else begin
          stallNow = reqStall;
        end
      end
      PEND: begin
        if (stallreq_if) begin
          stallNow = STALL_ALL;
        end else begin
          flushNow = 1'b1;
          newPcNow = pendPc_q;
          state_d  = GUARD;
        end
      end
      GUARD: begin
        stallNow = reqStall;
        state_d  = RUN;
      end
      default: state_d = RUN;
    endcase
    if (rst) begin
      state_d  = RUN;
      pendPc_d = 32'h0;
      stallNow = STALL_NONE;
      flushNow = 1'b0;
      newPcNow = 32'h0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= RUN;
      pendPc_q   <= 32'h0;
      stallCnt_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      pendPc_q <= pendPc_d;
      if (stallNow != STALL_NONE) stallCnt_q <= stallCnt_q + 32'd1;
    end
  end

  assign stall     = stallNow;
  assign flush     = flushNow;
  assign new_pc    = newPcNow;
  assign stall_cnt = stallCnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl: stall priority, exception
// redirect with and without a pending fetch, reset abandonment, counter wrap.
module tb_pipe_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
  logic [31:0] excepttype, cp0_epc;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc, stall_cnt;

  int errors = 0;
  int checks = 0;
  logic [31:0] expCnt;

  pipe_ctrl dut (
    .clk(clk), .rst(rst),
    .stallreq_if(stallreq_if), .stallreq_id(stallreq_id),
    .stallreq_ex(stallreq_ex), .stallreq_mem(stallreq_mem),
    .excepttype(excepttype), .cp0_epc(cp0_epc),
    .stall(stall), .flush(flush), .new_pc(new_pc), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  // Inputs change right after the falling edge; outputs are sampled 1ns later.
  task automatic setInputs(input logic r, input logic [3:0] req,
                           input logic [31:0] exc, input logic [31:0] epc);
    @(negedge clk);
    rst = r;
    {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = req;
    excepttype = exc;
    cp0_epc = epc;
    #1;
  endtask

  task automatic test_reset;
    setInputs(1'b1, 4'b1111, 32'h8, 32'h1234_5678);
    checks++;
    if (stall !== 6'b0 || flush !== 1'b0 || new_pc !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: stall=%b flush=%b new_pc=%h, want 0/0/0", stall, flush, new_pc);
    end
    @(posedge clk); #1;
    checks++;
    if (stall_cnt !== 32'h0) begin
      errors++;
      $display("[TB] FAIL reset_cnt: stall_cnt=%h, want 0", stall_cnt);
    end
    setInputs(1'b0, 4'b0000, 32'h0, 32'h0);
    checks++;
    if (stall !== 6'b0 || flush !== 1'b0) begin
      errors++;
      $display("[TB] FAIL post_reset_run: stall=%b flush=%b, want 0/0", stall, flush);
    end
    @(posedge clk);
    expCnt = 32'h0;
  endtask

  task automatic test_priority;
    logic [3:0] reqs [6]  = '{4'b0000, 4'b0001, 4'b0010, 4'b0110, 4'b1001, 4'b1111};
    logic [5:0] exps [6]  = '{6'b000000, 6'b000011, 6'b000111, 6'b001111, 6'b011111, 6'b011111};
    for (int i = 0; i < 6; i++) begin
      setInputs(1'b0, reqs[i], 32'h0, 32'h0);
      checks++;
      if (stall !== exps[i] || flush !== 1'b0 || new_pc !== 32'h0) begin
        errors++;
        $display("[TB] FAIL priority[%0d]: stall=%b flush=%b new_pc=%h, want %b/0/0", i, stall, flush, new_pc, exps[i]);
      end
      if (exps[i] != 6'b0) expCnt = expCnt + 32'd1;
      @(posedge clk); #1;
      checks++;
      if (stall_cnt !== expCnt) begin
        errors++;
        $display("[TB] FAIL priority_cnt[%0d]: stall_cnt=%0d, want %0d", i, stall_cnt, expCnt);
      end
    end
  endtask

  task automatic test_exception;
    setInputs(1'b0, 4'b0000, 32'h8, 32'h1234_5678);
    checks++;
    if (flush !== 1'b1 || new_pc !== 32'hBFC00380 || stall !== 6'b0) begin
      errors++;
      $display("[TB] FAIL exc_flush: flush=%b new_pc=%h stall=%b, want 1/bfc00380/0", flush, new_pc, stall);
    end
    @(posedge clk);
    // Guard cycle: exception still present is ignored, mem request stalls normally.
    setInputs(1'b0, 4'b1000, 32'h8, 32'h1234_5678);
    checks++;
    if (flush !== 1'b0 || new_pc !== 32'h0 || stall !== 6'b011111) begin
      errors++;
      $display("[TB] FAIL exc_guard: flush=%b new_pc=%h stall=%b, want 0/0/011111", flush, new_pc, stall);
    end
    expCnt = expCnt + 32'd1;
    @(posedge clk);
    setInputs(1'b0, 4'b0000, 32'he, 32'h8000_2000);
    checks++;
    if (flush !== 1'b1 || new_pc !== 32'h8000_2000) begin
      errors++;
      $display("[TB] FAIL eret_direct: flush=%b new_pc=%h, want 1/80002000", flush, new_pc);
    end
    @(posedge clk);
    setInputs(1'b0, 4'b0000, 32'h0, 32'h0);
    @(posedge clk); #1;
    checks++;
    if (stall_cnt !== expCnt) begin
      errors++;
      $display("[TB] FAIL exc_cnt: stall_cnt=%0d, want %0d", stall_cnt, expCnt);
    end
  endtask

  task automatic test_mask;
    setInputs(1'b0, 4'b1110, 32'hc, 32'h0);
    checks++;
    if (stall !== 6'b0 || flush !== 1'b1 || new_pc !== 32'hBFC00380) begin
      errors++;
      $display("[TB] FAIL mask: stall=%b flush=%b new_pc=%h, want 0/1/bfc00380", stall, flush, new_pc);
    end
    @(posedge clk);
    setInputs(1'b0, 4'b0000, 32'h0, 32'h0);
    @(posedge clk);
  endtask

  task automatic test_eret_pend;
    setInputs(1'b0, 4'b0001, 32'he, 32'h8000_1000);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) setInputs(1'b0, 4'b0001, 32'he, 32'hDEAD_BEEF);
      checks++;
      if (stall !== 6'b111111 || flush !== 1'b0 || new_pc !== 32'h0) begin
        errors++;
        $display("[TB] FAIL pend_stall[%0d]: stall=%b flush=%b new_pc=%h, want 111111/0/0", i, stall, flush, new_pc);
      end
      expCnt = expCnt + 32'd1;
      @(posedge clk);
    end
    setInputs(1'b0, 4'b0000, 32'he, 32'hDEAD_BEEF);
    checks++;
    if (flush !== 1'b1 || new_pc !== 32'h8000_1000 || stall !== 6'b0) begin
      errors++;
      $display("[TB] FAIL pend_flush: flush=%b new_pc=%h stall=%b, want 1/80001000/0", flush, new_pc, stall);
    end
    @(posedge clk);
    setInputs(1'b0, 4'b0000, 32'h0, 32'h0);
    checks++;
    if (flush !== 1'b0 || new_pc !== 32'h0) begin
      errors++;
      $display("[TB] FAIL pend_guard: flush=%b new_pc=%h, want 0/0", flush, new_pc);
    end
    @(posedge clk); #1;
    checks++;
    if (stall_cnt !== expCnt) begin
      errors++;
      $display("[TB] FAIL pend_cnt: stall_cnt=%0d, want %0d", stall_cnt, expCnt);
    end
  endtask

  task automatic test_reset_in_pend;
    setInputs(1'b0, 4'b0001, 32'h8, 32'h0);
    @(posedge clk);
    setInputs(1'b1, 4'b0001, 32'h8, 32'h0);
    checks++;
    if (stall !== 6'b0 || flush !== 1'b0) begin
      errors++;
      $display("[TB] FAIL rst_pend_hold: stall=%b flush=%b, want 0/0", stall, flush);
    end
    @(posedge clk);
    expCnt = 32'h0;
    for (int i = 0; i < 2; i++) begin
      setInputs(1'b0, 4'b0000, 32'h0, 32'h0);
      checks++;
      if (flush !== 1'b0 || stall !== 6'b0 || stall_cnt !== 32'h0) begin
        errors++;
        $display("[TB] FAIL rst_pend_after[%0d]: flush=%b stall=%b stall_cnt=%h, want 0/0/0", i, flush, stall, stall_cnt);
      end
      @(posedge clk);
    end
  endtask

  task automatic test_wrap;
    @(negedge clk);
    force dut.stallCnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.stallCnt_q;
    setInputs(1'b0, 4'b0010, 32'h0, 32'h0);
    checks++;
    if (stall_cnt !== 32'hFFFF_FFFF) begin
      errors++;
      $display("[TB] FAIL wrap_preset: stall_cnt=%h, want ffffffff", stall_cnt);
    end
    @(posedge clk); #1;
    checks++;
    if (stall_cnt !== 32'h0) begin
      errors++;
      $display("[TB] FAIL wrap: stall_cnt=%h, want 0", stall_cnt);
    end
    setInputs(1'b0, 4'b0000, 32'h0, 32'h0);
  endtask

  initial begin
    rst = 1'b1;
    {stallreq_mem, stallreq_ex, stallreq_id, stallreq_if} = 4'b0;
    excepttype = 32'h0;
    cp0_epc = 32'h0;
    expCnt = 32'h0;
    test_reset();
    test_priority();
    test_exception();
    test_mask();
    test_eret_pend();
    test_reset_in_pend();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
